// File: rtl/handshaked_reg_slice_pkg.sv
// rtl/handshaked_reg_slice_pkg.sv - shared state encoding for the handshaked register slice
package handshaked_reg_slice_pkg;

    localparam int OCC_W = 2;

    // State value doubles as the occupancy count
    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/handshaked_reg_slice.sv
// rtl/handshaked_reg_slice.sv - registered valid/ready stage with one-word skid buffer
module handshaked_reg_slice
    import handshaked_reg_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_vld,
    output logic                  a_rd,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_vld,
    input  logic                  b_rd,
    output logic [OCC_W-1:0]      occupancy
);

    generate
        if (DATA_WIDTH < 1) begin : g_bad_width
            $error("handshaked_reg_slice: DATA_WIDTH must be >= 1");
        end
    endgenerate

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  a_rd_q;
    logic                  b_vld_q;
    logic                  in_xfer;
    logic                  out_xfer;

    assign in_xfer  = a_vld & a_rd_q;
    assign out_xfer = b_vld_q & b_rd;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (in_xfer) state_d = ONE;
            ONE: begin
                if (in_xfer && !out_xfer)      state_d = FULL;
                else if (!in_xfer && out_xfer) state_d = EMPTY;
            end
            FULL:    if (out_xfer) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs are registered from the next state so ready/valid never see a comb path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            a_rd_q  <= 1'b0;
            b_vld_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            a_rd_q  <= (state_d != FULL);
            b_vld_q <= (state_d != EMPTY);
            if ((state_q == EMPTY && in_xfer) || (state_q == ONE && in_xfer && out_xfer))
                main_q <= a_data;
            else if (state_q == FULL && out_xfer)
                main_q <= skid_q;
            if (state_q == ONE && in_xfer && !out_xfer)
                skid_q <= a_data;
        end
    end

    assign a_rd      = a_rd_q;
    assign b_vld     = b_vld_q;
    assign b_data    = main_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_handshaked_reg_slice.sv
// tb/tb_handshaked_reg_slice.sv - self-checking bench for handshaked_reg_slice
module tb_handshaked_reg_slice;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [1:0] a_data2;
    logic       a_vld2, a_rd2, b_vld2, b_rd2;
    logic [1:0] b_data2, occ2;

    logic [2:0] a_data3;
    logic       a_vld3, a_rd3, b_vld3, b_rd3;
    logic [2:0] b_data3;
    logic [1:0] occ3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    handshaked_reg_slice #(.DATA_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data2), .a_vld(a_vld2), .a_rd(a_rd2),
        .b_data(b_data2), .b_vld(b_vld2), .b_rd(b_rd2),
        .occupancy(occ2)
    );

    handshaked_reg_slice #(.DATA_WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data3), .a_vld(a_vld3), .a_rd(a_rd3),
        .b_data(b_data3), .b_vld(b_vld3), .b_rd(b_rd3),
        .occupancy(occ3)
    );

    typedef struct {
        logic       a_vld;
        logic [1:0] a_data;
        logic       b_rd;
        logic       e_vld;
        logic [1:0] e_data;
        logic       e_rd;
        logic [1:0] e_occ;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] model_q[$];

    initial begin
        // streaming 0..3 then idle
        tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1};
        tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1};
        tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1};
        tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b1, 2'd3, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0};
        // backpressure fill, third word refused
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1};
        tbl[6]  = '{1'b1, 2'd2, 1'b0, 1'b1, 2'd1, 1'b0, 2'd2};
        tbl[7]  = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd1, 1'b0, 2'd2};
        // drain from FULL
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0};
        // simultaneous in/out at ONE
        tbl[11] = '{1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1};
        tbl[12] = '{1'b1, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1};
        tbl[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0};

        rst_n   = 1'b0;
        a_vld2  = 1'b0; a_data2 = '0; b_rd2 = 1'b1;
        a_vld3  = 1'b0; a_data3 = '0; b_rd3 = 1'b0;

        // reset held for 3 clocks with b_rd high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_a_rd", 32'(a_rd2), 32'd0);
            chk("rst_b_vld", 32'(b_vld2), 32'd0);
            chk("rst_occ", 32'(occ2), 32'd0);
        end
        #2 rst_n = 1'b1;
        tick();
        chk("rel_a_rd", 32'(a_rd2), 32'd1);
        chk("rel_b_vld", 32'(b_vld2), 32'd0);
        chk("rel_occ", 32'(occ2), 32'd0);
        chk("rel_a_rd3", 32'(a_rd3), 32'd1);

        for (int i = 0; i < 14; i++) begin
            a_vld2  = tbl[i].a_vld;
            a_data2 = tbl[i].a_data;
            b_rd2   = tbl[i].b_rd;
            tick();
            chk($sformatf("vec%0d_b_vld", i), 32'(b_vld2), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d_a_rd", i), 32'(a_rd2), 32'(tbl[i].e_rd));
            chk($sformatf("vec%0d_occ", i), 32'(occ2), 32'(tbl[i].e_occ));
            if (tbl[i].e_vld)
                chk($sformatf("vec%0d_b_data", i), 32'(b_data2), 32'(tbl[i].e_data));
        end
        a_vld2 = 1'b0;

        // fill the 3-bit stage, then reset asynchronously mid-cycle
        a_vld3 = 1'b1; a_data3 = 3'd5; b_rd3 = 1'b0;
        tick();
        a_data3 = 3'd6;
        tick();
        a_vld3 = 1'b0;
        chk("w3_full_occ", 32'(occ3), 32'd2);
        chk("w3_full_data", 32'(b_data3), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_b_vld", 32'(b_vld3), 32'd0);
        chk("async_occ", 32'(occ3), 32'd0);
        chk("async_a_rd", 32'(a_rd3), 32'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("w3_rel_b_vld", 32'(b_vld3), 32'd0);
        a_vld3 = 1'b1; a_data3 = 3'd7; b_rd3 = 1'b1;
        tick();
        a_vld3 = 1'b0;
        chk("w3_seven_vld", 32'(b_vld3), 32'd1);
        chk("w3_seven_data", 32'(b_data3), 32'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w3_no_stale", 32'(b_vld3), 32'd0);
        end

        // random traffic against a queue model
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic do_in, do_out;
            a_vld3  = ($urandom_range(0, 3) != 0);
            a_data3 = 3'($urandom_range(0, 7));
            b_rd3   = ($urandom_range(0, 2) != 0);
            #1;
            chk("rnd_occ", 32'(occ3), 32'(model_q.size()));
            chk("rnd_a_rd", 32'(a_rd3), 32'(model_q.size() < 2));
            chk("rnd_b_vld", 32'(b_vld3), 32'(model_q.size() > 0));
            if (model_q.size() > 0)
                chk("rnd_b_data", 32'(b_data3), 32'(model_q[0]));
            do_in  = a_vld3 && (model_q.size() < 2);
            do_out = b_rd3 && (model_q.size() > 0);
            if (do_out) void'(model_q.pop_front());
            if (do_in) model_q.push_back(a_data3);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
